// File: rtl/vga_layer_scheduler_if.sv
// ---------------------------------------------------------------------------
// vga_layer_scheduler_if
// Configuration bus for the VGA layer scheduler. A master presents one layer
// description (target layer, enable, inclusive x/y window, colour) together
// with cfg_valid; the slave answers with cfg_ready and the write is taken in
// any cycle where both are high.
//
// Signals:
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  write can be accepted this cycle
//   cfg_layer  master->slave  target layer index
//   cfg_en     master->slave  layer enable
//   cfg_x0/x1  master->slave  inclusive horizontal range
//   cfg_y0/y1  master->slave  inclusive vertical range
//   cfg_color  master->slave  packed colour {R[2:0],G[2:0],B[2:0]}
// ---------------------------------------------------------------------------
interface vga_layer_scheduler_if #(
   parameter int N_LAYERS = 4,
   parameter int COORD_W  = 11,
   parameter int RGB_W    = 9
);
   localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

   logic               cfg_valid;
   logic               cfg_ready;
   logic [LAYER_W-1:0] cfg_layer;
   logic               cfg_en;
   logic [COORD_W-1:0] cfg_x0;
   logic [COORD_W-1:0] cfg_x1;
   logic [COORD_W-1:0] cfg_y0;
   logic [COORD_W-1:0] cfg_y1;
   logic [RGB_W-1:0]   cfg_color;

   modport master (
      output cfg_valid, cfg_layer, cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_layer, cfg_en, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color,
      output cfg_ready
   );
endinterface

// File: rtl/vga_layer_scheduler.sv
// ---------------------------------------------------------------------------
// vga_layer_scheduler
// Shares the RGB pins of a 1280x1024 VGA output between N_LAYERS rectangular
// colour layers by fixed priority (layer 0 highest). Layer descriptions are
// written into per-layer pending registers through the cfg bus and only copied
// into the active set on frame_sync, so a frame never shows a half-updated
// scene.
//
// Ports:
//   CLK         pixel clock
//   RST_N       asynchronous reset, active low
//   xpos/ypos   current pixel, 1-based inside the display, 0 in blanking
//   frame_sync  one-cycle pulse per frame during vertical blanking
//   cfg         configuration bus (slave side)
//   rgb         registered pixel colour, two cycles after xpos/ypos
//   hit_valid   rgb came from a layer
//   hit_layer   winning layer index, 0 when no layer won
//   frame_cnt   number of commits since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module vga_layer_scheduler #(
   parameter int               N_LAYERS = 4,
   parameter int               COORD_W  = 11,
   parameter int               RGB_W    = 9,
   parameter logic [RGB_W-1:0] BG_COLOR = 9'h000,
   localparam int              LAYER_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [COORD_W-1:0]  xpos,
   input  logic [COORD_W-1:0]  ypos,
   input  logic                frame_sync,
   vga_layer_scheduler_if.slave cfg,
   output logic [RGB_W-1:0]    rgb,
   output logic                hit_valid,
   output logic [LAYER_W-1:0]  hit_layer,
   output logic [15:0]         frame_cnt
);

   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] y1;
      logic [RGB_W-1:0]   color;
   } layer_t;

   layer_t              pend_q [N_LAYERS];
   layer_t              act_q  [N_LAYERS];
   logic [N_LAYERS-1:0] pend_flag_q;

   layer_t              cfg_word;
   logic                cfg_accept;

   logic                win_valid;
   logic [LAYER_W-1:0]  win_layer;
   logic [RGB_W-1:0]    win_color;
   logic                blank;

   logic                s1_blank;
   logic                s1_valid;
   logic [LAYER_W-1:0]  s1_layer;
   logic [RGB_W-1:0]    s1_color;

   // A layer that already holds an uncommitted write refuses further writes
   // until frame_sync drains it, so no pending value is ever overwritten.
   assign cfg.cfg_ready = !pend_flag_q[cfg.cfg_layer];
   assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;
   assign cfg_word      = '{en: cfg.cfg_en, x0: cfg.cfg_x0, x1: cfg.cfg_x1,
                            y0: cfg.cfg_y0, y1: cfg.cfg_y1, color: cfg.cfg_color};

   // Pending/active register file. Commit only touches layers whose flag is
   // set, and an accept only happens on a layer whose flag is clear, so the
   // two never fight over the same layer; a write accepted during frame_sync
   // stays pending until the following frame_sync.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < N_LAYERS; i++) begin
            pend_q[i] <= '0;
            act_q[i]  <= '0;
         end
         pend_flag_q <= '0;
         frame_cnt   <= '0;
      end else begin
         if (frame_sync) begin
            frame_cnt <= frame_cnt + 16'd1;
            for (int i = 0; i < N_LAYERS; i++) begin
               if (pend_flag_q[i]) begin
                  act_q[i]       <= pend_q[i];
                  pend_flag_q[i] <= 1'b0;
               end
            end
         end
         if (cfg_accept) begin
            pend_q[cfg.cfg_layer]      <= cfg_word;
            pend_flag_q[cfg.cfg_layer] <= 1'b1;
         end
      end
   end

   // Hit test and priority resolve for the incoming pixel. The winner's colour
   // is captured together with the hit so a commit landing between the two
   // pipeline stages cannot pair old geometry with a new colour. Scanning from
   // the highest index down lets the lowest hitting index overwrite the rest.
   always_comb begin
      win_valid = 1'b0;
      win_layer = '0;
      win_color = BG_COLOR;
      blank     = (xpos == '0) || (ypos == '0);
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (act_q[i].en &&
             (act_q[i].x0 <= xpos) && (xpos <= act_q[i].x1) &&
             (act_q[i].y0 <= ypos) && (ypos <= act_q[i].y1)) begin
            win_valid = 1'b1;
            win_layer = LAYER_W'(i);
            win_color = act_q[i].color;
         end
      end
   end

   // Stage 1 register: resolved hit plus the blanking flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_blank <= 1'b0;
         s1_valid <= 1'b0;
         s1_layer <= '0;
         s1_color <= '0;
      end else begin
         s1_blank <= blank;
         s1_valid <= win_valid;
         s1_layer <= win_layer;
         s1_color <= win_color;
      end
   end

   // Stage 2 register: blanking forces black, otherwise the winning layer or
   // the background colour drives the pins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rgb       <= '0;
         hit_valid <= 1'b0;
         hit_layer <= '0;
      end else if (s1_blank) begin
         rgb       <= '0;
         hit_valid <= 1'b0;
         hit_layer <= '0;
      end else if (s1_valid) begin
         rgb       <= s1_color;
         hit_valid <= 1'b1;
         hit_layer <= s1_layer;
      end else begin
         rgb       <= BG_COLOR;
         hit_valid <= 1'b0;
         hit_layer <= '0;
      end
   end

endmodule
